// File: rtl/myproject_prod_accum_sat.sv
// Dot-product accumulator: sums N_TERMS signed products, shifts by FRAC_SHIFT and saturates to OUT_W.
// Build option MYPROJECT_ACC_ROUND_EN selects round-half-up; otherwise the shift truncates toward -inf.

module myproject_prod_accum_sat_chk #(
  parameter int OUT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  input logic             last,
  input logic             din_rdy,
  input logic [OUT_W-1:0] dout,
  input logic             dout_vld,
  input logic             dout_rdy,
  input logic             dout_sat
);

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (dout_vld && !dout_rdy) |=> (dout_vld && $stable(dout) && $stable(dout_sat)));

  a_rdy_acc: assert property (@(posedge clk) disable iff (!rst_n)
    !last |-> din_rdy);

endmodule

module myproject_prod_accum_sat #(
  parameter int PROD_W     = 39,
  parameter int N_TERMS    = 4,
  parameter int FRAC_SHIFT = 10,
  parameter int OUT_W      = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic [OUT_W-1:0]  dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              dout_sat
);

  localparam int ACC_W = PROD_W + $clog2(N_TERMS);
  localparam int CNT_W = $clog2(N_TERMS);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(N_TERMS - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(N_TERMS - 2);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_LAST = 1'b1;

  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W + 1 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [ACC_W:0] RND_ONE = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] RND_HALF = RND_ONE << (FRAC_SHIFT - 1);

  // Clip a widened result into OUT_W bits; the MSB of the return flags clipping.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [ACC_W:0] v);
    logic [OUT_W:0] res;
    if (v > SAT_MAX) begin
      res = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (v < SAT_MIN) begin
      res = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      res = {1'b0, v[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [0:0]              phase_r;
  logic [0:0]              phase_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic [OUT_W-1:0]        dout_r;
  logic                    dout_vld_r;
  logic                    dout_sat_r;

  logic                    last_s;
  logic                    din_rdy_s;
  logic                    in_fire_s;
  logic                    out_fire_s;
  logic                    out_load_s;
  logic signed [ACC_W:0]   din_ext_s;
  logic signed [ACC_W:0]   acc_ext_s;
  logic signed [ACC_W:0]   sum_s;
  logic signed [ACC_W:0]   rnd_s;
  logic signed [ACC_W:0]   shr_s;
  logic [OUT_W:0]          sat_pack_s;

  // Handshakes: only the last term can stall, and only behind an undrained result.
  always_comb begin
    last_s     = (phase_r == ST_LAST);
    din_rdy_s  = !(last_s && dout_vld_r && !dout_rdy);
    in_fire_s  = din_vld && din_rdy_s;
    out_fire_s = dout_vld_r && dout_rdy;
    out_load_s = in_fire_s && last_s;
  end

  // Datapath: widen, sum, optionally round, shift and clip.
  always_comb begin
    din_ext_s = {{(ACC_W + 1 - PROD_W){din[PROD_W-1]}}, din};
    acc_ext_s = {acc_r[ACC_W-1], acc_r};
    sum_s     = acc_ext_s + din_ext_s;
`ifdef MYPROJECT_ACC_ROUND_EN
    rnd_s     = sum_s + RND_HALF;
`else
    rnd_s     = sum_s;
`endif
    shr_s      = rnd_s >>> FRAC_SHIFT;
    sat_pack_s = sat_fn(shr_s);
    if (cnt_r == CNT_ZERO) begin
      acc_nxt_s = din_ext_s[ACC_W-1:0];
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
  end

  // Two-phase control and term counter next state.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    if (in_fire_s) begin
      case (phase_r)
        ST_ACC: begin
          cnt_nxt_s   = cnt_r + CNT_ONE;
          phase_nxt_s = (cnt_r == CNT_PENULT) ? ST_LAST : ST_ACC;
        end
        ST_LAST: begin
          cnt_nxt_s   = CNT_ZERO;
          phase_nxt_s = ST_ACC;
        end
        default: begin
          cnt_nxt_s   = CNT_ZERO;
          phase_nxt_s = ST_ACC;
        end
      endcase
    end else begin
      cnt_nxt_s   = cnt_r;
      phase_nxt_s = phase_r;
    end
  end

  // Control state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_r   <= CNT_ZERO;
      phase_r <= ST_ACC;
    end else begin
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  // Accumulator: first term of a group loads, later terms add.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (in_fire_s) begin
      acc_r <= acc_nxt_s;
    end
  end

  // Output register: a reload wins over a simultaneous drain.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dout_r     <= {OUT_W{1'b0}};
      dout_sat_r <= 1'b0;
      dout_vld_r <= 1'b0;
    end else if (out_load_s) begin
      dout_r     <= sat_pack_s[OUT_W-1:0];
      dout_sat_r <= sat_pack_s[OUT_W];
      dout_vld_r <= 1'b1;
    end else if (out_fire_s) begin
      dout_vld_r <= 1'b0;
    end
  end

  assign din_rdy  = din_rdy_s;
  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign dout_sat = dout_sat_r;

  myproject_prod_accum_sat_chk #(
    .OUT_W(OUT_W)
  ) u_chk (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .last     (last_s),
    .din_rdy  (din_rdy_s),
    .dout     (dout_r),
    .dout_vld (dout_vld_r),
    .dout_rdy (dout_rdy),
    .dout_sat (dout_sat_r)
  );

endmodule

// File: tb/tb_myproject_prod_accum_sat.sv
// Self-checking bench for myproject_prod_accum_sat with an expected-result queue.
// Expected rounding follows MYPROJECT_ACC_ROUND_EN when the bench is built with it.

module tb_myproject_prod_accum_sat;

  localparam int PROD_W = 39;
  localparam int OUT_W  = 16;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [PROD_W-1:0] din;
  logic              din_vld;
  logic              din_rdy;
  logic [OUT_W-1:0]  dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic              dout_sat;

  int checks = 0;
  int failures = 0;
  logic [OUT_W:0] sb_q[$];

  myproject_prod_accum_sat dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy),
    .dout_sat (dout_sat)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact sum, optional half-up rounding, floor shift, clip.
  function automatic logic [OUT_W:0] model(input longint t0, input longint t1,
                                           input longint t2, input longint t3);
    longint s;
    longint r;
    logic [OUT_W:0] res;
    s = t0 + t1 + t2 + t3;
`ifdef MYPROJECT_ACC_ROUND_EN
    s = s + 64'sd512;
`endif
    r = s >>> 10;
    if (r > 64'sd32767) res = {1'b1, 16'h7fff};
    else if (r < -64'sd32768) res = {1'b1, 16'h8000};
    else res = {1'b0, r[15:0]};
    return res;
  endfunction

  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send_term(input longint v);
    int waited;
    waited = 0;
    din = v[PROD_W-1:0];
    din_vld = 1'b1;
    #1;
    while (!din_rdy && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (din_rdy !== 1'b1) begin
      failures++;
      $display("FAIL send_timeout: din_rdy=%b after %0d cycles, required 1", din_rdy, waited);
    end
    tick();
    din_vld = 1'b0;
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0;
    din = '0;
    din_vld = 1'b0;
    dout_rdy = 1'b0;
    repeat (3) tick();
    checks++;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b required 0", dout_vld); end
    checks++;
    if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout: got %0d required 0", $signed(dout)); end
    checks++;
    if (dout_sat !== 1'b0) begin failures++; $display("FAIL reset_sat: got %b required 0", dout_sat); end
    checks++;
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b required 1", din_rdy); end
    ap_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [OUT_W:0] exp;
    dout_rdy = 1'b1;
    sb_q.push_back(model(1024, 2048, 3072, 4096));
    send_term(1024); send_term(2048); send_term(3072); send_term(4096);
    checks++;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL basic_vld: got %b required 1", dout_vld); end
    exp = sb_q.pop_front();
    checks++;
    if (dout !== exp[OUT_W-1:0] || dout_sat !== exp[OUT_W])
      begin failures++; $display("FAIL basic_out: got %0d/%b required %0d/%b", $signed(dout), dout_sat, $signed(exp[OUT_W-1:0]), exp[OUT_W]); end
    tick();
    checks++;
    if (dout_vld !== 1'b0 || dout !== exp[OUT_W-1:0])
      begin failures++; $display("FAIL basic_pulse: vld=%b dout=%0d required vld=0 dout=%0d", dout_vld, $signed(dout), $signed(exp[OUT_W-1:0])); end
  endtask

  task automatic run_groups(input string name, input longint g[2][4]);
    logic [OUT_W:0] exp;
    dout_rdy = 1'b1;
    for (int gi = 0; gi < 2; gi++) begin
      sb_q.push_back(model(g[gi][0], g[gi][1], g[gi][2], g[gi][3]));
      for (int k = 0; k < 4; k++) send_term(g[gi][k]);
      checks++;
      if (dout_vld !== 1'b1) begin failures++; $display("FAIL %s_vld%0d: got %b required 1", name, gi, dout_vld); end
      exp = sb_q.pop_front();
      checks++;
      if (dout !== exp[OUT_W-1:0] || dout_sat !== exp[OUT_W])
        begin failures++; $display("FAIL %s_out%0d: got %0d/%b required %0d/%b", name, gi, $signed(dout), dout_sat, $signed(exp[OUT_W-1:0]), exp[OUT_W]); end
      tick();
    end
  endtask

  task automatic test_saturation;
    longint g[2][4];
    for (int k = 0; k < 4; k++) begin
      g[0][k] = (64'sd1 <<< 38) - 64'sd1;
      g[1][k] = -(64'sd1 <<< 38);
    end
    run_groups("sat", g);
  endtask

  task automatic test_rounding;
    longint g[2][4];
    g[0] = '{64'sd1536, 64'sd0, 64'sd0, 64'sd0};
    g[1] = '{-64'sd1536, 64'sd0, 64'sd0, 64'sd0};
    run_groups("round", g);
  endtask

  task automatic test_backpressure;
    logic [OUT_W:0] exp;
    dout_rdy = 1'b0;
    sb_q.push_back(model(1024, 2048, 3072, 4096));
    send_term(1024); send_term(2048); send_term(3072); send_term(4096);
    sb_q.push_back(model(1024, 1024, 1024, 1024));
    send_term(1024); send_term(1024); send_term(1024);
    din = 39'd1024;
    din_vld = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b0) begin failures++; $display("FAIL bp_stall: din_rdy=%b required 0", din_rdy); end
    tick(); tick();
    exp = sb_q[0];
    checks++;
    if (din_rdy !== 1'b0 || dout_vld !== 1'b1 || dout !== exp[OUT_W-1:0])
      begin failures++; $display("FAIL bp_hold: rdy=%b vld=%b dout=%0d required 0/1/%0d", din_rdy, dout_vld, $signed(dout), $signed(exp[OUT_W-1:0])); end
    dout_rdy = 1'b1;
    #1;
    checks++;
    if (din_rdy !== 1'b1) begin failures++; $display("FAIL bp_release: din_rdy=%b required 1", din_rdy); end
    tick();
    din_vld = 1'b0;
    void'(sb_q.pop_front());
    exp = sb_q.pop_front();
    checks++;
    if (dout_vld !== 1'b1 || dout !== exp[OUT_W-1:0] || dout_sat !== exp[OUT_W])
      begin failures++; $display("FAIL bp_reload: vld=%b dout=%0d/%b required 1 %0d/%b", dout_vld, $signed(dout), dout_sat, $signed(exp[OUT_W-1:0]), exp[OUT_W]); end
    tick();
    checks++;
    if (dout_vld !== 1'b0) begin failures++; $display("FAIL bp_drain: vld=%b required 0", dout_vld); end
  endtask

  task automatic test_reset_mid;
    logic [OUT_W:0] exp;
    dout_rdy = 1'b0;
    for (int k = 0; k < 4; k++) send_term(1024);
    checks++;
    if (dout_vld !== 1'b1) begin failures++; $display("FAIL rst_pending: vld=%b required 1", dout_vld); end
    send_term(5000); send_term(5000);
    #2;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (dout_vld !== 1'b0 || dout !== 16'h0000 || dout_sat !== 1'b0)
      begin failures++; $display("FAIL rst_async: vld=%b dout=%0d sat=%b required 0/0/0", dout_vld, $signed(dout), dout_sat); end
    tick(); tick();
    ap_rst_n = 1'b1;
    tick();
    dout_rdy = 1'b1;
    sb_q.push_back(model(1024, 1024, 1024, 1024));
    for (int k = 0; k < 4; k++) send_term(1024);
    exp = sb_q.pop_front();
    checks++;
    if (dout_vld !== 1'b1 || dout !== exp[OUT_W-1:0] || dout_sat !== exp[OUT_W])
      begin failures++; $display("FAIL rst_residue: vld=%b dout=%0d/%b required 1 %0d/%b", dout_vld, $signed(dout), dout_sat, $signed(exp[OUT_W-1:0]), exp[OUT_W]); end
    tick();
  endtask

  task automatic test_back_to_back;
    longint vals[12];
    logic [OUT_W:0] exp;
    logic want_vld;
    vals = '{64'sd100000, -64'sd2000, 64'sd30000, 64'sd7,
             -64'sd500000, -64'sd1, -64'sd1, -64'sd1,
             64'sd33554432, 64'sd33554432, -64'sd3000, 64'sd12345};
    for (int gi = 0; gi < 3; gi++)
      sb_q.push_back(model(vals[4*gi], vals[4*gi+1], vals[4*gi+2], vals[4*gi+3]));
    dout_rdy = 1'b1;
    for (int k = 0; k < 12; k++) begin
      din = vals[k][PROD_W-1:0];
      din_vld = 1'b1;
      #1;
      checks++;
      if (din_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy%0d: got %b required 1", k, din_rdy); end
      tick();
      want_vld = ((k % 4) == 3);
      checks++;
      if (dout_vld !== want_vld) begin failures++; $display("FAIL b2b_vld%0d: got %b required %b", k, dout_vld, want_vld); end
      if (dout_vld === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++; $display("FAIL b2b_extra%0d: unexpected result %0d", k, $signed(dout));
        end else begin
          exp = sb_q.pop_front();
          if (dout !== exp[OUT_W-1:0] || dout_sat !== exp[OUT_W])
            begin failures++; $display("FAIL b2b_out%0d: got %0d/%b required %0d/%b", k, $signed(dout), dout_sat, $signed(exp[OUT_W-1:0]), exp[OUT_W]); end
        end
      end
    end
    din_vld = 1'b0;
    tick();
    checks++;
    if (dout_vld !== 1'b0 || sb_q.size() != 0)
      begin failures++; $display("FAIL b2b_end: vld=%b pending=%0d required 0/0", dout_vld, sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
